// File: rtl/dsp_be_patt_corr_unit_pkg.sv
// Shared DSP backend types: pattern flag/arithmetic bundles, pattern select codes,
// snapshot FSM states and the fixed-priority pattern resolve function.
package dsp_be_patt_corr_unit_pkg;

  localparam int unsigned NumPatt = 8;

  typedef struct packed {
    logic p1a;
    logic p1b;
    logic p2;
    logic p3o;
    logic p3a;
    logic p3b;
    logic p4p;
    logic p4m;
  } flag_unit_t;

  typedef struct packed {
    logic dpre;
    logic dpst;
    logic dcomp;
    logic dxn;
    logic dxp;
  } ari_unit_t;

  typedef enum logic [3:0] {
    PATT_NONE = 4'd0,
    PATT_P4M  = 4'd1,
    PATT_P4P  = 4'd2,
    PATT_P3A  = 4'd3,
    PATT_P3B  = 4'd4,
    PATT_P2   = 4'd5,
    PATT_P1A  = 4'd6,
    PATT_P1B  = 4'd7,
    PATT_P3O  = 4'd8
  } patt_sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } stat_state_t;

  typedef struct packed {
    logic      dout;
    patt_sel_t sel;
  } patt_res_t;

  function automatic patt_res_t patt_resolve(input flag_unit_t f, input ari_unit_t a);
    patt_res_t r;
    if (f.p4m)      r = '{dout: 1'b0,    sel: PATT_P4M};
    else if (f.p4p) r = '{dout: 1'b1,    sel: PATT_P4P};
    else if (f.p3a) r = '{dout: a.dpst,  sel: PATT_P3A};
    else if (f.p3b) r = '{dout: a.dpre,  sel: PATT_P3B};
    else if (f.p2)  r = '{dout: a.dcomp, sel: PATT_P2};
    else if (f.p1a) r = '{dout: a.dpst,  sel: PATT_P1A};
    else if (f.p1b) r = '{dout: a.dpre,  sel: PATT_P1B};
    else if (f.p3o) r = '{dout: a.dcomp, sel: PATT_P3O};
    else            r = '{dout: a.dpre,  sel: PATT_NONE};
    return r;
  endfunction

endpackage

// File: rtl/dsp_be_patt_corr_unit_stat_cnt.sv
// Saturating per-pattern hit counters with snapshot request/acknowledge FSM.
module dsp_be_patt_stat_cnt
  import dsp_be_patt_corr_unit_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_hit,
  input  patt_sel_t                         i_hit_sel,
  input  logic                              i_stat_req,
  input  logic                              i_stat_clr,
  output logic                              o_stat_ack,
  output logic [NumPatt-1:0][CntWidth-1:0]  o_stat_cnt
);

  stat_state_t                      state_q;
  logic                             ack_q;
  logic [NumPatt-1:0][CntWidth-1:0] live_q, live_d;
  logic [NumPatt-1:0][CntWidth-1:0] snap_q;
  logic [NumPatt-1:0]               hit_vec;
  logic                             accept;

  assign accept = (state_q == ST_IDLE) && i_stat_req;

  // A hit coinciding with a clearing snapshot survives as a count of 1.
  always_comb begin
    hit_vec = '0;
    live_d  = live_q;
    for (int unsigned k = 0; k < NumPatt; k++) begin
      hit_vec[k] = i_hit && (i_hit_sel == patt_sel_t'(4'(k + 1)));
      if (accept && i_stat_clr)
        live_d[k] = {{(CntWidth-1){1'b0}}, hit_vec[k]};
      else if (hit_vec[k] && (live_q[k] != '1))
        live_d[k] = live_q[k] + CntWidth'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      live_q  <= '0;
      snap_q  <= '0;
    end else begin
      live_q <= live_d;
      case (state_q)
        ST_IDLE: begin
          ack_q <= accept;
          if (accept) begin
            snap_q  <= live_q;
            state_q <= ST_ACK;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_stat_ack = ack_q;
  assign o_stat_cnt = snap_q;

endmodule

// File: rtl/dsp_be_patt_corr_unit.sv
// MLSE backend pattern correction: 2-stage priority resolve of pattern flags into a
// decision bit. Counters/snapshot built only with DSP_BE_PATT_STAT_EN defined.
module dsp_be_patt_corr_unit
  import dsp_be_patt_corr_unit_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  input  flag_unit_t                        i_flag_unit_d0,
  input  ari_unit_t                         i_ari_unit_dm1,
  input  logic                              i_stat_req,
  input  logic                              i_stat_clr,
  output logic                              o_valid,
  output logic                              o_dout,
  output patt_sel_t                         o_patt_sel,
  output logic                              o_stat_ack,
  output logic [NumPatt-1:0][CntWidth-1:0]  o_stat_cnt
);

  logic       v1_q;
  flag_unit_t flag1_q;
  ari_unit_t  ari1_q;
  logic       valid_q;
  logic       dout_q;
  patt_sel_t  sel_q;
  patt_res_t  res;
  logic       unused_ari;

  assign res        = patt_resolve(flag1_q, ari1_q);
  assign unused_ari = ^{ari1_q.dxn, ari1_q.dxp};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q    <= 1'b0;
      flag1_q <= '0;
      ari1_q  <= '0;
      valid_q <= 1'b0;
      dout_q  <= 1'b0;
      sel_q   <= PATT_NONE;
    end else begin
      v1_q    <= i_valid;
      valid_q <= v1_q;
      if (i_valid) begin
        flag1_q <= i_flag_unit_d0;
        ari1_q  <= i_ari_unit_dm1;
      end
      if (v1_q) begin
        dout_q <= res.dout;
        sel_q  <= res.sel;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_dout     = dout_q;
  assign o_patt_sel = sel_q;

`ifdef DSP_BE_PATT_STAT_EN
  dsp_be_patt_stat_cnt #(
    .CntWidth (CntWidth)
  ) u_stat (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_hit      (valid_q),
    .i_hit_sel  (sel_q),
    .i_stat_req (i_stat_req),
    .i_stat_clr (i_stat_clr),
    .o_stat_ack (o_stat_ack),
    .o_stat_cnt (o_stat_cnt)
  );
`else
  // Handshake kept without counters so firmware polling the ack never stalls.
  stat_state_t state_q;
  logic        ack_q;
  logic        unused_clr;

  assign unused_clr = i_stat_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= i_stat_req;
          if (i_stat_req) state_q <= ST_ACK;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_stat_ack = ack_q;
  assign o_stat_cnt = '0;
`endif

endmodule
